// File: rtl/imem_loader_if.sv
`default_nettype none
// Byte-stream (valid/ready) and instruction-memory write-port interfaces for imem_loader.
// Rev 1.0 - initial release.

interface byte_stream_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input  in_ready);
   modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

interface imem_wr_if #(
   parameter int ADDR_W = 16
);
   logic              wEn;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (output wEn, output wr_addr, output wr_data);
   modport slave  (input  wEn, input  wr_addr, input  wr_data);
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// imem_loader: framed byte-stream loader for the Y86-64 instruction memory (rev 1.0).
// Trailing XOR checksum byte is enabled by defining IMEM_LOAD_CHECKSUM_EN.

module imem_loader #(
   parameter int ADDR_W = 16
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   input  wire logic    start,
   byte_stream_if.slave s_in,
   imem_wr_if.master    m_wr,
   output logic         busy,
   output logic         done,
   output logic         load_err,
   output logic         cpu_hold
);

`ifdef IMEM_LOAD_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_HDR = 3'd1, S_LOAD = 3'd2, S_CSUM = 3'd3, S_DONE = 3'd4, S_ERR = 3'd5
   } state_t;
   localparam state_t c_after_payload = S_CSUM;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_HDR = 3'd1, S_LOAD = 3'd2, S_DONE = 3'd4, S_ERR = 3'd5
   } state_t;
   localparam state_t c_after_payload = S_DONE;
`endif

   localparam logic [17:0] c_depth = 18'd1 << ADDR_W;

   state_t            r_state;
   logic [1:0]        r_hdr_cnt;
   logic [15:0]       r_base;
   logic [7:0]        r_len_lo;
   logic [15:0]       r_remain;
   logic [ADDR_W-1:0] r_addr;
   logic              r_wen;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [7:0]        r_wr_data;
`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [7:0]        r_xor;
`endif

   logic        w_busy;
   logic        w_xfer;
   logic [15:0] w_len;
   logic [16:0] w_end;

`ifdef IMEM_LOAD_CHECKSUM_EN
   assign w_busy = (r_state == S_HDR) || (r_state == S_LOAD) || (r_state == S_CSUM);
`else
   assign w_busy = (r_state == S_HDR) || (r_state == S_LOAD);
`endif
   assign w_xfer = s_in.in_valid && w_busy;
   assign w_len  = {s_in.in_data, r_len_lo};
   // One bit wider than the address space so an oversize frame is caught before any write.
   assign w_end  = {1'b0, r_base} + {1'b0, w_len};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_hdr_cnt <= 2'd0;
         r_base    <= 16'd0;
         r_len_lo  <= 8'd0;
         r_remain  <= 16'd0;
         r_addr    <= '0;
         r_wen     <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= 8'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
         r_xor     <= 8'd0;
`endif
      end else begin
         r_wen <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_state   <= S_HDR;
                  r_hdr_cnt <= 2'd0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                  r_xor     <= 8'd0;
`endif
               end
            end
            S_HDR: begin
               if (w_xfer) begin
                  r_hdr_cnt <= r_hdr_cnt + 2'd1;
                  case (r_hdr_cnt)
                     2'd0: r_base[7:0]  <= s_in.in_data;
                     2'd1: r_base[15:8] <= s_in.in_data;
                     2'd2: r_len_lo     <= s_in.in_data;
                     default: begin
                        r_remain <= w_len;
                        r_addr   <= r_base[ADDR_W-1:0];
                        if ({1'b0, w_end} > c_depth) r_state <= S_ERR;
                        else if (w_len == 16'd0)     r_state <= c_after_payload;
                        else                         r_state <= S_LOAD;
                     end
                  endcase
               end
            end
            S_LOAD: begin
               if (w_xfer) begin
                  r_wen     <= 1'b1;
                  r_wr_addr <= r_addr;
                  r_wr_data <= s_in.in_data;
                  r_addr    <= r_addr + 1'b1;
                  r_remain  <= r_remain - 16'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                  r_xor     <= r_xor ^ s_in.in_data;
`endif
                  if (r_remain == 16'd1) r_state <= c_after_payload;
               end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            S_CSUM: begin
               if (w_xfer) r_state <= (s_in.in_data == r_xor) ? S_DONE : S_ERR;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_in.in_ready = w_busy;
   assign busy          = w_busy;
   assign done          = (r_state == S_DONE);
   assign load_err      = (r_state == S_ERR);
   assign cpu_hold      = (r_state != S_DONE);
   assign m_wr.wEn      = r_wen;
   assign m_wr.wr_addr  = r_wr_addr;
   assign m_wr.wr_data  = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader: randomized self-checking bench; expected writes and outcome come from a frame-level model.
// Rev 1.0 - initial release.

module tb_imem_loader;
   typedef logic [7:0] u8;
   typedef struct packed { logic [31:0] cyc; logic [15:0] a; logic [7:0] d; } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic busy, done, load_err, cpu_hold;
   int   n_tests = 0;
   int   n_fail  = 0;

   byte_stream_if s_if ();
   imem_wr_if #(.ADDR_W(16)) w_if ();

   imem_loader #(.ADDR_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .s_in     (s_if),
      .m_wr     (w_if),
      .busy     (busy),
      .done     (done),
      .load_err (load_err),
      .cpu_hold (cpu_hold)
   );

   always #5 clk = ~clk;

   wr_t         obs_q[$];
   logic [31:0] cyc_cnt = 32'd0;
   always @(posedge clk) begin
      #2;
      cyc_cnt = cyc_cnt + 32'd1;
      if (w_if.wEn === 1'b1) obs_q.push_back({cyc_cnt, w_if.wr_addr, w_if.wr_data});
   end

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Drives bytes until every one has been accepted; start_at raises start alongside that byte.
   task automatic drive_bytes(input u8 b[$], input int mode, input int start_at, output bit ok);
      int i = 0;
      int guard = 0;
      bit acc;
      while (i < b.size() && guard < 500) begin
         case (mode)
            0:       s_if.in_valid = 1'b1;
            1:       s_if.in_valid = (guard[0] == 1'b0);
            default: s_if.in_valid = ($urandom_range(0, 3) != 0);
         endcase
         s_if.in_data = b[i];
         start = (i == start_at) && s_if.in_valid;
         acc = s_if.in_valid && s_if.in_ready;
         @(posedge clk); #1;
         start = 1'b0;
         if (acc) i++;
         guard++;
      end
      s_if.in_valid = 1'b0;
      ok = (i == b.size());
   endtask

   task automatic run_frame(input string name, input logic [15:0] base, input logic [15:0] len,
                            input u8 pl[$], input int mode, input int start_at, input bit csum_good);
      u8    fr[$];
      u8    x = 8'h00;
      wr_t  exp_q[$];
      bit   hdr_bad, exp_ok, exp_wen, ok;
      hdr_bad = ({16'h0, base} + {16'h0, len}) > 32'h10000;
      fr = {base[7:0], base[15:8], len[7:0], len[15:8]};
      exp_ok = !hdr_bad;
      if (!hdr_bad) begin
         for (int k = 0; k < int'(len); k++) begin
            fr.push_back(pl[k]);
            x ^= pl[k];
            exp_q.push_back({32'd0, base + 16'(k), pl[k]});
         end
`ifdef IMEM_LOAD_CHECKSUM_EN
         fr.push_back(csum_good ? x : ((x == 8'h00) ? 8'hFF : 8'h00));
         exp_ok = csum_good;
`endif
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      exp_wen = 1'b0;
`else
      exp_wen = !hdr_bad && (len != 16'd0);
`endif
      obs_q.delete();
      pulse_start();
      n_tests++;
      if ({busy, done, load_err, s_if.in_ready} !== 4'b1001) begin
         n_fail++;
         $display("FAIL %s.start_state: got busy/done/err/rdy=%b expected 1001", name, {busy, done, load_err, s_if.in_ready});
      end
      drive_bytes(fr, mode, start_at, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s.accept: got stalled stream expected all %0d bytes accepted", name, fr.size());
      end
      n_tests++;
      if ({done, load_err, cpu_hold, busy, s_if.in_ready, w_if.wEn} !== {exp_ok, !exp_ok, !exp_ok, 1'b0, 1'b0, exp_wen}) begin
         n_fail++;
         $display("FAIL %s.end_state: got done/err/hold/busy/rdy/wEn=%b expected %b", name,
                  {done, load_err, cpu_hold, busy, s_if.in_ready, w_if.wEn}, {exp_ok, !exp_ok, !exp_ok, 1'b0, 1'b0, exp_wen});
      end
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL %s.write_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            n_tests++;
            if (obs_q[k].a !== exp_q[k].a || obs_q[k].d !== exp_q[k].d) begin
               n_fail++;
               $display("FAIL %s.write[%0d]: got %h=%h expected %h=%h", name, k, obs_q[k].a, obs_q[k].d, exp_q[k].a, exp_q[k].d);
            end
            if (mode == 0 && k > 0) begin
               n_tests++;
               if (obs_q[k].cyc !== obs_q[0].cyc + 32'(k)) begin
                  n_fail++;
                  $display("FAIL %s.consecutive[%0d]: got cycle %0d expected %0d", name, k, obs_q[k].cyc, obs_q[0].cyc + 32'(k));
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if ({s_if.in_ready, w_if.wEn, w_if.wr_addr, w_if.wr_data, busy, done, load_err, cpu_hold} !== {2'b00, 16'h0, 8'h0, 4'b0001}) begin
         n_fail++;
         $display("FAIL reset.in_reset: got %h expected %h",
                  {s_if.in_ready, w_if.wEn, w_if.wr_addr, w_if.wr_data, busy, done, load_err, cpu_hold}, {2'b00, 16'h0, 8'h0, 4'b0001});
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({s_if.in_ready, busy, done, load_err, cpu_hold} !== 5'b00001) begin
         n_fail++;
         $display("FAIL reset.idle: got %b expected 00001", {s_if.in_ready, busy, done, load_err, cpu_hold});
      end
   endtask

   task automatic test_basic();
      run_frame("basic", 16'h0000, 16'd3, '{8'h30, 8'hF0, 8'h0A}, 0, -1, 1'b1);
   endtask

   task automatic test_hdr_error();
      run_frame("hdr_err", 16'hFFFE, 16'd3, '{}, 0, -1, 1'b1);
      run_frame("hdr_fit", 16'hFFFD, 16'd3, '{8'h11, 8'h22, 8'h33}, 0, -1, 1'b1);
   endtask

   task automatic test_stall();
      run_frame("stall", 16'h0014, 16'd2, '{8'h60, 8'hBA}, 1, -1, 1'b1);
   endtask

   task automatic test_checksum();
`ifdef IMEM_LOAD_CHECKSUM_EN
      run_frame("csum_good", 16'h0000, 16'd3, '{8'h30, 8'hF0, 8'h0A}, 0, -1, 1'b1);
      run_frame("csum_bad", 16'h0000, 16'd3, '{8'h30, 8'hF0, 8'h0A}, 0, -1, 1'b0);
`endif
   endtask

   task automatic test_reset_midload();
      u8  fr[$];
      bit ok;
      obs_q.delete();
      pulse_start();
      fr = {8'h00, 8'h01, 8'h03, 8'h00, 8'hAA};
      drive_bytes(fr, 0, -1, ok);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({s_if.in_ready, w_if.wEn, w_if.wr_addr, w_if.wr_data, busy, done, load_err, cpu_hold} !== {2'b00, 16'h0, 8'h0, 4'b0001}) begin
         n_fail++;
         $display("FAIL midload.async_reset: got %h expected %h",
                  {s_if.in_ready, w_if.wEn, w_if.wr_addr, w_if.wr_data, busy, done, load_err, cpu_hold}, {2'b00, 16'h0, 8'h0, 4'b0001});
      end
      n_tests++;
      if (obs_q.size() != 1 || obs_q[0].a !== 16'h0100 || obs_q[0].d !== 8'hAA) begin
         n_fail++;
         $display("FAIL midload.partial_write: got %0d writes expected 1 write 0100=aa", obs_q.size());
      end
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_frame("after_reset", 16'h0200, 16'd3, '{8'h10, 8'h20, 8'h30}, 0, -1, 1'b1);
   endtask

   task automatic test_len_zero();
      run_frame("len_zero", 16'h0040, 16'd0, '{}, 0, -1, 1'b1);
   endtask

   task automatic test_start_during_load();
      run_frame("start_mid", 16'h0300, 16'd4, '{8'h01, 8'h02, 8'h03, 8'h04}, 0, 5, 1'b1);
`ifdef IMEM_LOAD_CHECKSUM_EN
      run_frame("start_last", 16'h0400, 16'd2, '{8'hA5, 8'h5A}, 0, 6, 1'b1);
`else
      run_frame("start_last", 16'h0400, 16'd2, '{8'hA5, 8'h5A}, 0, 5, 1'b1);
`endif
      n_tests++;
      if ({busy, done} !== 2'b01) begin
         n_fail++;
         $display("FAIL start_last.ignored: got busy/done=%b expected 01", {busy, done});
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         logic [15:0] base, len;
         u8 pl[$];
         len  = 16'($urandom_range(0, 8));
         base = (it % 3 == 0) ? 16'(16'hFFFF - $urandom_range(0, 6)) : 16'($urandom_range(0, 16'hFFF0));
         for (int k = 0; k < int'(len); k++) pl.push_back(u8'($urandom_range(0, 255)));
         run_frame($sformatf("rand%0d", it), base, len, pl, 2, -1, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      s_if.in_valid = 1'b0;
      s_if.in_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_hdr_error();
      test_stall();
      test_checksum();
      test_reset_midload();
      test_len_zero();
      test_start_during_load();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
